// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 host definitions
// Purpose: transmitter state encoding, PS/2 command constants, default timing
//          constants and the host-to-device frame builder.
// Ports:   none (package).
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    START     = 3'd2,
    SEND      = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } tx_state_t;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_ECHO    = 8'hEE;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] ACK_BYTE    = 8'hFA;

  // 50 MHz system clock: 100 us inhibit, 15 ms transfer timeout
  localparam int DEF_INHIBIT_CYC = 5000;
  localparam int DEF_TIMEOUT_CYC = 750000;
  localparam int DEF_FILT_LEN    = 4;

  // Bits shifted out after the start bit, LSB first: data, odd parity, stop.
  function automatic logic [9:0] make_frame(input logic [7:0] d);
    return {1'b1, ~^d, d};
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// rtl/ps2_host_tx_if.sv - command byte handshake between client and PS/2 transmitter
// Purpose: groups the byte request/response signals of ps2_host_tx.
// Signals: tx_data  command byte            (master -> slave)
//          tx_valid request                 (master -> slave)
//          tx_ready transmitter idle        (slave -> master)
//          busy     transfer in progress    (slave -> master)
//          tx_done  byte sent and acked     (slave -> master, 1-cycle pulse)
//          tx_err   no ack or timeout       (slave -> master, 1-cycle pulse)
interface ps2_host_tx_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       tx_done;
  logic       tx_err;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, busy, tx_done, tx_err
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, busy, tx_done, tx_err
  );

endinterface

// File: rtl/ps2_line_sync.sv
// rtl/ps2_line_sync.sv - PS/2 pad synchronizer, clock glitch filter and fall strobe
// Purpose: brings the asynchronous PS/2 clock/data pads into the clk domain and
//          produces a one-cycle strobe on each accepted ps2_clk falling edge.
// Ports:   clk, rst   system clock, async active-high reset
//          clk_pad    raw ps2_clk pad sample
//          data_pad   raw ps2_data pad sample
//          clk_sync   2-flop synchronized ps2_clk
//          data_sync  2-flop synchronized ps2_data
//          clk_fall   1-cycle pulse when the filtered clock goes 1->0
module ps2_line_sync #(
  parameter int FILT_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clk_pad,
  input  logic data_pad,
  output logic clk_sync,
  output logic data_sync,
  output logic clk_fall
);

  localparam int CW = $clog2(FILT_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_LEN - 1);

  logic          clk_meta;
  logic          data_meta;
  logic          clk_filt;
  logic [CW-1:0] cnt;

  // Idle bus level is high, so the synchronizers reset to 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_meta  <= clk_pad;
      clk_sync  <= clk_meta;
      data_meta <= data_pad;
      data_sync <= data_meta;
    end
  end

  // cnt counts consecutive synced samples that differ from the filtered level;
  // the FILT_LEN-th one flips the level. Any agreeing sample restarts the run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_filt <= 1'b1;
      cnt      <= '0;
      clk_fall <= 1'b0;
    end else begin
      clk_fall <= 1'b0;
      if (clk_sync == clk_filt) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        clk_filt <= clk_sync;
        cnt      <= '0;
        clk_fall <= clk_filt;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter
// Purpose: inhibits the bus, issues a start bit, shifts out one command byte
//          with odd parity and stop bit on device clock falls, checks the
//          device ack and reports done/err. Lines are driven open-drain via
//          output enables (pad = oe ? 1'b0 : 1'bz at the top level).
// Ports:   clk, rst     system clock, async active-high reset
//          tx           byte handshake (ps2_host_tx_if.slave)
//          ps2_clk_in   PS/2 clock pad sample (async)
//          ps2_data_in  PS/2 data pad sample (async)
//          ps2_clk_oe   1 = pull ps2_clk low
//          ps2_data_oe  1 = pull ps2_data low
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYC = DEF_INHIBIT_CYC,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int FILT_LEN    = DEF_FILT_LEN
) (
  input  logic          clk,
  input  logic          rst,
  ps2_host_tx_if.slave  tx,
  input  logic          ps2_clk_in,
  input  logic          ps2_data_in,
  output logic          ps2_clk_oe,
  output logic          ps2_data_oe
);

  localparam int IW = (INHIBIT_CYC > 1) ? $clog2(INHIBIT_CYC) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYC - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC);

  tx_state_t     state;
  tx_state_t     state_nxt;
  logic [9:0]    frame;
  logic [3:0]    bit_idx;
  logic [IW-1:0] inh_cnt;
  logic [TW-1:0] to_cnt;
  logic          data_bit_oe;
  logic          ack_q;

  logic          clk_sync;
  logic          data_sync;
  logic          clk_fall;

  logic          on_wire;
  logic          inh_last;
  logic          timed_out;
  logic          lines_idle;

  ps2_line_sync #(
    .FILT_LEN (FILT_LEN)
  ) u_line_sync (
    .clk       (clk),
    .rst       (rst),
    .clk_pad   (ps2_clk_in),
    .data_pad  (ps2_data_in),
    .clk_sync  (clk_sync),
    .data_sync (data_sync),
    .clk_fall  (clk_fall)
  );

  // Timeout window covers everything after the clock is handed to the device.
  assign on_wire    = (state == SEND) || (state == ACK) || (state == WAIT_IDLE);
  assign inh_last   = (inh_cnt == INH_LAST);
  assign timed_out  = on_wire && (to_cnt == TO_LAST);
  assign lines_idle = clk_sync && data_sync;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (tx.tx_valid) state_nxt = INHIBIT;
      INHIBIT:   if (inh_last) state_nxt = START;
      START:     state_nxt = SEND;
      SEND: begin
        if (timed_out)                         state_nxt = IDLE;
        else if (clk_fall && bit_idx == 4'd9)  state_nxt = ACK;
      end
      ACK: begin
        if (timed_out)      state_nxt = IDLE;
        else if (clk_fall)  state_nxt = WAIT_IDLE;
      end
      WAIT_IDLE: if (timed_out || lines_idle) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Frame shifter, counters and ack capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame       <= '0;
      bit_idx     <= '0;
      inh_cnt     <= '0;
      to_cnt      <= '0;
      data_bit_oe <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (tx.tx_valid) begin
            frame   <= make_frame(tx.tx_data);
            inh_cnt <= '0;
          end
        end
        INHIBIT: inh_cnt <= inh_cnt + 1'b1;
        START: begin
          // Start bit (data low) stays on the line until the first fall.
          to_cnt      <= '0;
          bit_idx     <= '0;
          data_bit_oe <= 1'b1;
          ack_q       <= 1'b0;
        end
        SEND: begin
          to_cnt <= to_cnt + 1'b1;
          if (clk_fall) begin
            data_bit_oe <= ~frame[0];
            frame       <= {1'b0, frame[9:1]};
            bit_idx     <= bit_idx + 1'b1;
          end
        end
        ACK: begin
          to_cnt <= to_cnt + 1'b1;
          if (clk_fall) ack_q <= ~data_sync;
        end
        WAIT_IDLE: to_cnt <= to_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  // Outputs; a timeout releases data in the same cycle the error pulses.
  always_comb begin
    tx.tx_ready = (state == IDLE);
    tx.busy     = (state != IDLE);
    ps2_clk_oe  = (state == INHIBIT) || (state == START);
    ps2_data_oe = (state == START) ||
                  (((state == SEND) || (state == ACK)) && data_bit_oe && !timed_out);
    tx.tx_done  = (state == WAIT_IDLE) && lines_idle && ack_q && !timed_out;
    tx.tx_err   = timed_out || ((state == WAIT_IDLE) && lines_idle && !ack_q);
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter; the send-side counterpart of the keyboard scan receiver.
- Sends one command byte to the keyboard, e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable.
- Drives the open-drain PS/2 clock/data lines through output-enable pins; top level ties pads as pad = oe ? 1'b0 : 1'bz.
- Asserts busy so the receiver path can ignore line activity during a transmission.

Parameters:
- INHIBIT_CYC, 5000: clk cycles ps2_clk is held low before the start bit (100 us at 50 MHz).
- TIMEOUT_CYC, 750000: max clk cycles from clock release to the end of the ack/idle phase (15 ms at 50 MHz).
- FILT_LEN, 4: consecutive equal synced samples needed to accept a ps2_clk level change.

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  asynchronous, active-high reset
- tx_data  in  8  command byte
- tx_valid  in  1  request; accepted when tx_valid && tx_ready
- tx_ready  out  1  high only in IDLE
- busy  out  1  high in every state except IDLE
- tx_done  out  1  one-cycle pulse: byte sent and acknowledged
- tx_err  out  1  one-cycle pulse: no ack or timeout
- ps2_clk_in  in  1  PS/2 clock pad sample (async)
- ps2_data_in  in  1  PS/2 data pad sample (async)
- ps2_clk_oe  out  1  1 = pull ps2_clk low
- ps2_data_oe  out  1  1 = pull ps2_data low

Behaviour:
- Reset (async, immediate): state IDLE, tx_ready=1, busy=0, tx_done=0, tx_err=0, both oe=0 (lines released mid-frame), all counters 0.
- Input conditioning: 2-flop sync on both pads, then glitch filter on clk (FILT_LEN).
- fall = filtered clk 1->0. Worst-case detection latency is 2+FILT_LEN cycles after the pad edge.
- Acceptance: on tx_valid && tx_ready, latch the frame {stop=1, parity=~^tx_data (odd), tx_data}. tx_valid while not ready is ignored.
- IDLE -> INHIBIT on acceptance.
- INHIBIT: ps2_clk_oe=1 for exactly INHIBIT_CYC cycles, then go to START.
- START: one cycle with ps2_clk_oe=1 and ps2_data_oe=1 (start bit 0). Next cycle: clk_oe=0, timeout counter cleared and enabled, go to SEND with bit index 0.
- SEND, on each fall:
  - present the next frame bit, LSB first: ps2_data_oe = ~bit, updated the cycle after fall.
  - falls 1-8 carry data bits 0-7, fall 9 carries parity, fall 10 carries stop (data_oe=0).
  - after fall 10, go to ACK.
- ACK: on fall 11, sample filtered-synced data; ack = (data==0). Go to WAIT_IDLE.
- WAIT_IDLE: wait until synced clk=1 and data=1.
  - If ack: pulse tx_done.
  - Else: pulse tx_err.
  - Then go to IDLE.
- Timeout: if the counter reaches TIMEOUT_CYC in SEND/ACK/WAIT_IDLE:
  - release both oe,
  - pulse tx_err,
  - go to IDLE.
  - tx_done and tx_err are never both high.
- Device-initiated traffic while IDLE: no line driving. Host inhibit takes priority once a request is accepted.
- tx_ready returns high the cycle after the done/err pulse. A back-to-back tx_valid on that cycle is accepted.
- Latency with INHIBIT_CYC=5000: tx_ready falls 1 cycle after acceptance, ps2_clk_oe rises the same cycle, ps2_clk_oe falls at cycle 5002.

Decomposition:
- Shared package ps2_pkg:
  - state encoding (IDLE, INHIBIT, START, SEND, ACK, WAIT_IDLE),
  - command constants CMD_SET_LED=8'hED, CMD_ECHO=8'hEE, CMD_ENABLE=8'hF4, CMD_RESET=8'hFF, ACK_BYTE=8'hFA,
  - default timing constants.
- Sub-module ps2_line_sync: 2-flop synchronizer, clk glitch filter, fall-edge strobe. It is reusable by the receiver.

Test Plan:
- Send 8'hED with a device model clocking at 12.5 kHz and acking -> data bits 1,0,1,1,0,1,1,1 then parity 1, stop 1 sampled by the model on rising edges; one tx_done pulse; tx_err=0.
- Send 8'h00 -> parity bit 1. Send 8'hFF -> parity bit 1. Send 8'h01 -> parity bit 0. Model sees correct odd parity each time.
- Device model never clocks -> ps2_clk_oe low after INHIBIT_CYC+1; tx_err pulses exactly TIMEOUT_CYC cycles after clock release; both oe=0; tx_ready=1.
- Device model gives 11 clocks but leaves data high at ack -> tx_err pulse, no tx_done.
- Assert rst during SEND after bit 3 -> ps2_clk_oe=0 and ps2_data_oe=0 in the same cycle; tx_ready=1 after release. A following 8'hF4 transfer completes with tx_done.
- tx_valid held high across a whole transfer -> exactly one byte per tx_ready window. 1-cycle glitches on ps2_clk_in shorter than FILT_LEN -> no extra bit shifted.
